// File: rtl/descrypt_pkg.sv
// Shared constants for the DES crypt match collector.
// Candidate tag layout: {salt[11:0], key[55:0]} = 68 bits.
// Target register layout: {salt[11:0], expected {L,R} pre-FP [63:0]} = 76 bits.
package descrypt_pkg;

   localparam int SALT_W = 12;
   localparam int KEY_W  = 56;
   localparam int TAG_W  = 68;
   localparam int HALF_W = 32;
   localparam int HASH_W = 2 * HALF_W;
   localparam int TGT_W  = SALT_W + HASH_W;

   // Tag field offsets
   localparam int TAG_SALT_MSB = 67;
   localparam int TAG_SALT_LSB = 56;
   localparam int TAG_KEY_MSB  = 55;
   localparam int TAG_KEY_LSB  = 0;

   // Target field offsets
   localparam int TGT_SALT_MSB = 75;
   localparam int TGT_SALT_LSB = 64;
   localparam int TGT_HASH_MSB = 63;
   localparam int TGT_HASH_LSB = 0;

   function automatic logic [SALT_W-1:0] tag_salt(input logic [TAG_W-1:0] tag);
      return tag[TAG_SALT_MSB:TAG_SALT_LSB];
   endfunction

   function automatic logic [KEY_W-1:0] tag_key(input logic [TAG_W-1:0] tag);
      return tag[TAG_KEY_MSB:TAG_KEY_LSB];
   endfunction

endpackage

// File: rtl/match_fifo.sv
// Synchronous FIFO holding matched candidate tags.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (empties the FIFO)
//   push, din  - write din at the tail; caller only pushes when not full or
//                when popping in the same cycle
//   pop        - advance the head; caller only pops when not empty
//   dout       - head entry (meaningful only when !empty)
//   empty/full - occupancy flags
module match_fifo
   import descrypt_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      dout     = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: nothing is visible while the FIFO is empty.
   // On push-while-full-with-pop the write lands in the slot being vacated.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/descrypt_match_collector.sv
// Output stage of the unrolled salted DES crypt pipeline.
// Registers each finished candidate (stage 1), compares it against the
// host-programmed salt/hash, registers the hit (stage 2) and buffers hits
// in a FIFO drained by the host.
// Ports:
//   CLK, RST              - clock, synchronous active-high reset
//   IN_VALID, L, R, K     - finished candidate: halves pre-FP, {salt,key} tag
//   TARGET_WE, TARGET_IN  - load {salt, expected {L,R}}; clears counter and
//                           overflow and drops in-flight candidates
//   MATCH_VALID/READY     - head-of-FIFO handshake: an entry is consumed on
//                           every edge where both are high; READY alone is
//                           ignored
//   MATCH_KEY, MATCH_SALT - head entry (hold last shown value when empty)
//   CHECKED_CNT           - candidates compared since reset / target load
//   OVERFLOW              - sticky: a hit was dropped because FIFO was full
module descrypt_match_collector
   import descrypt_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 48
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   input  logic [31:0]       L,
   input  logic [31:0]       R,
   input  logic [67:0]       K,
   input  logic              TARGET_WE,
   input  logic [75:0]       TARGET_IN,
   output logic              MATCH_VALID,
   input  logic              MATCH_READY,
   output logic [55:0]       MATCH_KEY,
   output logic [11:0]       MATCH_SALT,
   output logic [CNT_W-1:0]  CHECKED_CNT,
   output logic              OVERFLOW
);

   logic              s1_valid_q, s1_valid_d;
   logic [HALF_W-1:0] s1_l_q, s1_l_d;
   logic [HALF_W-1:0] s1_r_q, s1_r_d;
   logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
   logic [TGT_W-1:0]  target_q, target_d;
   logic              s2_hit_q, s2_hit_d;
   logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [TAG_W-1:0]  last_tag_q, last_tag_d;

   logic              hit;
   logic              push_req;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_empty;
   logic              fifo_full;
   logic [TAG_W-1:0]  fifo_dout;
   logic [TAG_W-1:0]  head_tag;

   always_comb begin
      // Stage 1: a target load kills the candidate arriving on the same edge.
      s1_valid_d = IN_VALID & ~TARGET_WE;
      s1_l_d     = L;
      s1_r_d     = R;
      s1_tag_d   = K;
      target_d   = TARGET_WE ? TARGET_IN : target_q;

      hit = s1_valid_q &&
            (tag_salt(s1_tag_q) == target_q[TGT_SALT_MSB:TGT_SALT_LSB]) &&
            ({s1_l_q, s1_r_q} == target_q[TGT_HASH_MSB:TGT_HASH_LSB]);

      // Stage 2
      s2_hit_d = hit & ~TARGET_WE;
      s2_tag_d = s1_tag_q;

      // A hit sitting in stage 2 at the load edge was compared against the
      // old target; it is discarded rather than pushed.
      push_req  = s2_hit_q & ~TARGET_WE;
      fifo_pop  = ~fifo_empty & MATCH_READY;
      fifo_push = push_req & (~fifo_full | fifo_pop);

      if (TARGET_WE)     ovf_d = 1'b0;
      else               ovf_d = ovf_q | (push_req & fifo_full & ~fifo_pop);

      if (TARGET_WE)       cnt_d = '0;
      else if (s1_valid_q) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      else                 cnt_d = cnt_q;

      // Remember the head so the key/salt outputs hold once the FIFO drains.
      last_tag_d = fifo_empty ? last_tag_q : fifo_dout;
      head_tag   = fifo_empty ? last_tag_q : fifo_dout;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_valid_q <= 1'b0;
         s1_l_q     <= '0;
         s1_r_q     <= '0;
         s1_tag_q   <= '0;
         target_q   <= '0;
         s2_hit_q   <= 1'b0;
         s2_tag_q   <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         last_tag_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_l_q     <= s1_l_d;
         s1_r_q     <= s1_r_d;
         s1_tag_q   <= s1_tag_d;
         target_q   <= target_d;
         s2_hit_q   <= s2_hit_d;
         s2_tag_q   <= s2_tag_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         last_tag_q <= last_tag_d;
      end
   end

   match_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (TAG_W)
   ) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (s2_tag_q),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign MATCH_VALID = ~fifo_empty;
   assign MATCH_KEY   = tag_key(head_tag);
   assign MATCH_SALT  = tag_salt(head_tag);
   assign CHECKED_CNT = cnt_q;
   assign OVERFLOW    = ovf_q;

endmodule
